// File: rtl/npu_pkg.sv
// Shared widths, saturation limits and lane slicing for the NPU datapath stages.
package npu_pkg;

  localparam int LANES   = 32;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 16;
  localparam int SHIFT_W = 4;
  localparam int SUM_W   = ACC_W + 1;

  localparam logic [OUT_W-1:0] OUT_MAX = 16'h7FFF;
  localparam logic [OUT_W-1:0] OUT_MIN = 16'h8000;

  function automatic logic [ACC_W-1:0] acc_lane(input logic [LANES*ACC_W-1:0] v,
                                                input int unsigned k);
    return v[k*ACC_W +: ACC_W];
  endfunction

endpackage

// File: rtl/requant_lane.sv
// Combinational per-lane rounding right shift (round half up) and signed saturation.
module requant_lane
  import npu_pkg::*;
(
  input  logic [SUM_W-1:0]   sum,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   dat,
  output logic               sat
);

  localparam logic signed [SUM_W:0] RES_MAX = (SUM_W+1)'($signed(OUT_MAX));
  localparam logic signed [SUM_W:0] RES_MIN = (SUM_W+1)'($signed(OUT_MIN));

  logic signed [SUM_W:0] ext;
  logic signed [SUM_W:0] rnd;
  logic signed [SUM_W:0] res;

  always_comb begin
    ext = $signed({sum[SUM_W-1], sum});
    rnd = ext;
    // One extra bit of headroom so adding the half-LSB can never wrap.
    if (shift != '0) rnd = ext + ((SUM_W+1)'(1) << (shift - 1'b1));
    res = rnd >>> shift;
    sat = 1'b0;
    dat = res[OUT_W-1:0];
    if (res > RES_MAX) begin
      dat = OUT_MAX;
      sat = 1'b1;
    end else if (res < RES_MIN) begin
      dat = OUT_MIN;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/bias_requant.sv
// Two-stage bias add / requantise pipeline feeding the ReLU stage, with a
// writable per-lane bias file and a saturated-beat counter.
module bias_requant
  import npu_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_bias_wr,
  input  logic [4:0]               i_bias_addr,
  input  logic [OUT_W-1:0]         i_bias_wdat,
  input  logic [SHIFT_W-1:0]       i_shift,
  input  logic                     i_relu_en,
  input  logic                     i_acc_vld,
  output logic                     o_acc_rdy,
  input  logic [LANES*ACC_W-1:0]   i_acc_dat,
  output logic                     o_dat_vld,
  input  logic                     i_dat_rdy,
  output logic [LANES*OUT_W-1:0]   o_dat,
  output logic                     o_relu_en,
  input  logic                     i_sat_clr,
  output logic [15:0]              o_sat_cnt
);

  logic [OUT_W-1:0]         bias_q [LANES];
  logic [SUM_W-1:0]         sum_d  [LANES];
  logic [SUM_W-1:0]         s1_sum [LANES];
  logic                     s1_vld;
  logic [SHIFT_W-1:0]       s1_shift;
  logic                     s1_relu;
  logic [OUT_W-1:0]         lane_dat [LANES];
  logic [LANES-1:0]         lane_sat;
  logic [LANES*OUT_W-1:0]   dat_d;
  logic                     s2_sat;
  logic                     s1_en;
  logic                     s2_en;
  logic                     acc_xfer;
  logic                     out_xfer;

  assign s2_en     = !o_dat_vld || i_dat_rdy;
  assign s1_en     = !s1_vld || s2_en;
  assign o_acc_rdy = s1_en;
  assign acc_xfer  = i_acc_vld && s1_en;
  assign out_xfer  = o_dat_vld && i_dat_rdy;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [ACC_W-1:0] acc_k;
    assign acc_k    = acc_lane(i_acc_dat, k);
    assign sum_d[k] = {acc_k[ACC_W-1], acc_k}
                    + {{(SUM_W-OUT_W){bias_q[k][OUT_W-1]}}, bias_q[k]};

    requant_lane u_lane (
      .sum   (s1_sum[k]),
      .shift (s1_shift),
      .dat   (lane_dat[k]),
      .sat   (lane_sat[k])
    );

    assign dat_d[k*OUT_W +: OUT_W] = lane_dat[k];
  end

  // Bias is read combinationally at acceptance, so a same-cycle write lands after the beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < LANES; k++) bias_q[k] <= '0;
    end else if (i_bias_wr) begin
      bias_q[i_bias_addr] <= i_bias_wdat;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld   <= 1'b0;
      s1_shift <= '0;
      s1_relu  <= 1'b0;
      for (int k = 0; k < LANES; k++) s1_sum[k] <= '0;
    end else if (s1_en) begin
      s1_vld <= i_acc_vld;
      if (i_acc_vld) begin
        s1_shift <= i_shift;
        s1_relu  <= i_relu_en;
        for (int k = 0; k < LANES; k++) s1_sum[k] <= sum_d[k];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_dat_vld <= 1'b0;
      o_dat     <= '0;
      o_relu_en <= 1'b0;
      s2_sat    <= 1'b0;
    end else if (s2_en) begin
      o_dat_vld <= s1_vld;
      if (s1_vld) begin
        o_dat     <= dat_d;
        o_relu_en <= s1_relu;
        s2_sat    <= |lane_sat;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sat_cnt <= '0;
    end else if (i_sat_clr) begin
      o_sat_cnt <= '0;
    end else if (out_xfer && s2_sat && (o_sat_cnt != 16'hFFFF)) begin
      o_sat_cnt <= o_sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bias_requant.sv
// Bench for bias_requant: directed vector table, hand sequences and a randomized
// stream checked every cycle against an arithmetic reference model.
module tb_bias_requant;
  import npu_pkg::*;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_bias_wr;
  logic [4:0]    i_bias_addr;
  logic [15:0]   i_bias_wdat;
  logic [3:0]    i_shift;
  logic          i_relu_en;
  logic          i_acc_vld;
  logic          o_acc_rdy;
  logic [1023:0] i_acc_dat;
  logic          o_dat_vld;
  logic          i_dat_rdy;
  logic [511:0]  o_dat;
  logic          o_relu_en;
  logic          i_sat_clr;
  logic [15:0]   o_sat_cnt;

  always #5 i_clk = ~i_clk;

  bias_requant dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_bias_wr   (i_bias_wr),
    .i_bias_addr (i_bias_addr),
    .i_bias_wdat (i_bias_wdat),
    .i_shift     (i_shift),
    .i_relu_en   (i_relu_en),
    .i_acc_vld   (i_acc_vld),
    .o_acc_rdy   (o_acc_rdy),
    .i_acc_dat   (i_acc_dat),
    .o_dat_vld   (o_dat_vld),
    .i_dat_rdy   (i_dat_rdy),
    .o_dat       (o_dat),
    .o_relu_en   (o_relu_en),
    .i_sat_clr   (i_sat_clr),
    .o_sat_cnt   (o_sat_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [511:0] dat;
    logic         relu;
    logic         sat;
    int           cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] bias_m [32];
  logic [15:0] cnt_m = '0;
  int          cyc   = 0;
  int          n_out = 0;

  function automatic logic [16:0] ref_lane(input longint s, input int sh);
    longint r;
    if (sh == 0) r = s;
    else         r = (s + (longint'(1) << (sh - 1))) >>> sh;
    if (r > 32767)  return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  function automatic exp_t ref_beat(input logic [1023:0] acc, input logic [3:0] sh,
                                    input logic relu, input int c);
    exp_t        e;
    logic [16:0] l;
    logic [31:0] a;
    e.dat  = '0;
    e.sat  = 1'b0;
    e.relu = relu;
    e.cyc  = c;
    for (int k = 0; k < 32; k++) begin
      a = acc[k*32 +: 32];
      l = ref_lane(longint'($signed(a)) + longint'($signed(bias_m[k])), int'(sh));
      e.dat[k*16 +: 16] = l[15:0];
      e.sat = e.sat | l[16];
    end
    return e;
  endfunction

  logic exp_vld, exp_rdy, xfer;

  always @(negedge i_clk) begin
    if (i_rst) begin
      sb.delete();
      for (int k = 0; k < 32; k++) bias_m[k] = '0;
      cnt_m = '0;
    end else begin
      cyc++;
      exp_vld = (sb.size() > 0) && (cyc >= sb[0].cyc + 2);
      exp_rdy = !((sb.size() == 2) && !i_dat_rdy);
      chk("mon_vld", o_dat_vld, exp_vld);
      chk("mon_rdy", o_acc_rdy, exp_rdy);
      chk("mon_cnt", o_sat_cnt, cnt_m);
      if (exp_vld) begin
        chk("mon_dat", o_dat, sb[0].dat);
        chk("mon_relu", o_relu_en, sb[0].relu);
      end
      xfer = exp_vld && i_dat_rdy;
      if (i_sat_clr) cnt_m = '0;
      else if (xfer && sb[0].sat && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      if (xfer) begin
        void'(sb.pop_front());
        n_out++;
      end
      if (i_acc_vld && exp_rdy) sb.push_back(ref_beat(i_acc_dat, i_shift, i_relu_en, cyc));
      if (i_bias_wr) bias_m[i_bias_addr] = i_bias_wdat;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr_bias(input int addr, input logic [15:0] val);
    i_bias_wr   = 1'b1;
    i_bias_addr = 5'(addr);
    i_bias_wdat = val;
    tick();
    i_bias_wr   = 1'b0;
  endtask

  task automatic wait_out(output int waited);
    waited = 0;
    while (!o_dat_vld && waited < 20) begin
      tick();
      waited++;
    end
    if (!o_dat_vld) chk("wait_out_timeout", 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_lane();
    case ($urandom % 5)
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 65535)) - 32'd32768;
      3: return 32'($urandom_range(0, 1 << 20)) - 32'(1 << 19);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [1023:0] rand_acc();
    logic [1023:0] w;
    for (int k = 0; k < 32; k++) w[k*32 +: 32] = rand_lane();
    return w;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0] bias [4];
    logic [31:0] acc  [4];
    logic [3:0]  shift;
    logic [15:0] exp  [4];
    logic        exp_sat;
  } vec_t;

  vec_t vecs [6];
  int   lid  [4];

  function automatic vec_t mk(input logic [15:0] b0, b1, b2, b3,
                              input logic [31:0] a0, a1, a2, a3,
                              input logic [3:0] sh,
                              input logic [15:0] e0, e1, e2, e3,
                              input logic es);
    vec_t v;
    v.bias[0] = b0; v.bias[1] = b1; v.bias[2] = b2; v.bias[3] = b3;
    v.acc[0]  = a0; v.acc[1]  = a1; v.acc[2]  = a2; v.acc[3]  = a3;
    v.exp[0]  = e0; v.exp[1]  = e1; v.exp[2]  = e2; v.exp[3]  = e3;
    v.shift   = sh;
    v.exp_sat = es;
    return v;
  endfunction

  initial begin
    int            waited;
    int            exp_cnt;
    int            base;
    int            sent;
    logic          saw_block;
    logic [1023:0] acc;
    logic [511:0]  ew;

    lid = '{0, 1, 2, 31};
    // lanes 0,1,2,31: bias, acc, shift, expected, any-sat
    vecs[0] = mk(16'h0010, 16'h0000, 16'h0000, 16'hFFF0,
                 32'h0000_0100, 32'h0, 32'h0, 32'h0000_0005, 4'd0,
                 16'h0110, 16'h0000, 16'h0000, 16'hFFF5, 1'b0);
    vecs[1] = mk(16'h0, 16'h0, 16'h0, 16'h0,
                 32'd24, -32'sd24, 32'd23, 32'h0, 4'd4,
                 16'h0002, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    vecs[2] = mk(16'h0, 16'h0, 16'h0, 16'h0,
                 32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'h0, 4'd0,
                 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 1'b1);
    vecs[3] = mk(16'h7FFF, 16'h8000, 16'h0, 16'h0,
                 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_4000, 32'h0, 4'd15,
                 16'h7FFF, 16'h8000, 16'h0001, 16'h0000, 1'b1);
    vecs[4] = mk(16'h0, 16'h0, 16'h0, 16'h0,
                 32'd1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 4'd1,
                 16'h0001, 16'h0000, 16'h0002, 16'hFFFF, 1'b0);
    vecs[5] = mk(16'h0, 16'h0, 16'h0, 16'h0,
                 32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_7FFF, 4'd0,
                 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b1);

    i_rst = 1'b1; i_bias_wr = 0; i_bias_addr = 0; i_bias_wdat = 0; i_shift = 0;
    i_relu_en = 0; i_acc_vld = 0; i_acc_dat = '0; i_dat_rdy = 0; i_sat_clr = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_vld", o_dat_vld, 1'b0);
    chk("rst_dat", o_dat, '0);
    chk("rst_relu", o_relu_en, 1'b0);
    chk("rst_cnt", o_sat_cnt, 16'h0);
    chk("rst_rdy_empty", o_acc_rdy, 1'b1);
    i_rst = 1'b0;
    tick();
    i_dat_rdy = 1'b1;

    // Directed vectors: expected values are hand-computed constants.
    exp_cnt = 0;
    for (int v = 0; v < 6; v++) begin
      for (int j = 0; j < 4; j++) wr_bias(lid[j], vecs[v].bias[j]);
      acc = '0;
      for (int j = 0; j < 4; j++) acc[lid[j]*32 +: 32] = vecs[v].acc[j];
      i_acc_dat = acc;
      i_shift   = vecs[v].shift;
      i_relu_en = v[0];
      i_acc_vld = 1'b1;
      tick();
      i_acc_vld = 1'b0;
      wait_out(waited);
      chk($sformatf("vec%0d_latency", v), waited, 1);
      for (int j = 0; j < 4; j++)
        chk($sformatf("vec%0d_lane%0d", v, lid[j]), o_dat[lid[j]*16 +: 16], vecs[v].exp[j]);
      chk($sformatf("vec%0d_relu", v), o_relu_en, v[0]);
      tick();
      exp_cnt += int'(vecs[v].exp_sat);
      chk($sformatf("vec%0d_satcnt", v), o_sat_cnt, exp_cnt);
    end
    i_sat_clr = 1'b1;
    tick();
    i_sat_clr = 1'b0;
    chk("sat_clr", o_sat_cnt, 16'h0);

    // Bias write in the same cycle as an accepted beat.
    for (int j = 0; j < 4; j++) wr_bias(lid[j], 16'h0);
    wr_bias(0, 16'd5);
    i_acc_dat = '0; i_shift = 0; i_acc_vld = 1'b1;
    i_bias_wr = 1'b1; i_bias_addr = 5'd0; i_bias_wdat = 16'd9;
    tick();
    i_bias_wr = 1'b0;
    tick();
    i_acc_vld = 1'b0;
    wait_out(waited);
    chk("bias_old", o_dat[15:0], 16'd5);
    tick();
    chk("bias_new_vld", o_dat_vld, 1'b1);
    chk("bias_new", o_dat[15:0], 16'd9);
    tick();

    // Eight back-to-back beats, downstream stalled in cycles 3-5.
    base = n_out; sent = 0; saw_block = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      i_dat_rdy = !(c >= 3 && c <= 5);
      i_acc_vld = (sent < 8);
      i_acc_dat = rand_acc();
      i_shift   = 4'($urandom_range(0, 15));
      i_relu_en = 1'($urandom);
      #1;
      if (i_acc_vld && o_acc_rdy) sent++;
      if (!o_acc_rdy) saw_block = 1'b1;
      @(posedge i_clk);
      #1;
    end
    i_acc_vld = 1'b0; i_dat_rdy = 1'b1;
    repeat (4) tick();
    chk("stream_sent", sent, 8);
    chk("stream_out", n_out - base, 8);
    chk("stream_backpressure", saw_block, 1'b1);
    chk("stream_drained", sb.size(), 0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      i_dat_rdy   = ($urandom % 4) != 0;
      i_acc_vld   = ($urandom % 3) != 0;
      i_acc_dat   = rand_acc();
      i_shift     = 4'($urandom_range(0, 15));
      i_relu_en   = 1'($urandom);
      i_bias_wr   = ($urandom % 6) == 0;
      i_bias_addr = 5'($urandom);
      i_bias_wdat = 16'($urandom);
      i_sat_clr   = ($urandom % 60) == 0;
      tick();
    end
    i_acc_vld = 0; i_bias_wr = 0; i_sat_clr = 0; i_dat_rdy = 1'b1;
    repeat (4) tick();
    chk("rand_drained", sb.size(), 0);

    // Reset with two beats in flight.
    i_dat_rdy = 1'b0;
    i_acc_dat = rand_acc(); i_acc_vld = 1'b1;
    tick();
    i_acc_dat = rand_acc();
    tick();
    i_acc_vld = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_vld", o_dat_vld, 1'b0);
    chk("arst_dat", o_dat, '0);
    chk("arst_cnt", o_sat_cnt, 16'h0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_dat_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("arst_no_out", o_dat_vld, 1'b0);
      tick();
    end
    acc = '0; ew = '0;
    for (int k = 0; k < 32; k++) begin
      acc[k*32 +: 32] = 32'(k * 3);
      ew[k*16 +: 16]  = 16'(k * 3);
    end
    i_acc_dat = acc; i_shift = 0; i_relu_en = 1'b1; i_acc_vld = 1'b1;
    tick();
    i_acc_vld = 1'b0;
    wait_out(waited);
    chk("arst_bias_zero", o_dat, ew);
    chk("arst_relu", o_relu_en, 1'b1);
    tick();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bias_requant.md
Name: bias_requant

Overview:
- Stage directly upstream of the ReLU stage. It takes 32 lanes of 32-bit signed accumulator results from the PE array and adds a per-lane 16-bit signed bias.
- It then applies a rounding arithmetic right shift and saturates each lane to 16-bit signed.
- It emits a packed 512-bit word plus a ReLU enable, ready to drive the ReLU stage's bias-data and calc-enable inputs.
- It is a two-stage valid/ready pipeline with a writable bias register file and a saturation-event counter.

Parameters:
- LANES, 32, number of parallel lanes
- ACC_W, 32, accumulator width per lane (signed)
- OUT_W, 16, output width per lane (signed); also the bias width
- SHIFT_W, 4, width of the right-shift amount

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_bias_wr  in  1  bias register write strobe
- i_bias_addr  in  5  lane index for bias write
- i_bias_wdat  in  16  signed bias value
- i_shift  in  4  right-shift amount, 0..15, sampled with each accepted beat
- i_relu_en  in  1  ReLU enable, sampled with each accepted beat
- i_acc_vld  in  1  input beat valid
- o_acc_rdy  out  1  input beat ready
- i_acc_dat  in  1024  lane k at bits [32k+31:32k]
- o_dat_vld  out  1  output beat valid
- i_dat_rdy  in  1  downstream ready
- o_dat  out  512  lane k at bits [16k+15:16k], saturated result
- o_relu_en  out  1  i_relu_en carried with the beat
- i_sat_clr  in  1  synchronous clear of o_sat_cnt
- o_sat_cnt  out  16  count of output beats with at least one saturated lane

Behaviour:
- Reset (async, i_rst=1):
  - o_dat_vld=0, o_dat=0, o_relu_en=0, o_sat_cnt=0.
  - All bias registers=0; both pipeline stages empty.
  - Deassertion is synchronous to i_clk.
- Bias register file:
  - 32 x 16-bit. Writes on the clock edge when i_bias_wr=1.
  - A beat accepted in the same cycle as a write uses the old bias; later beats use the new one.
- Handshake:
  - Beat accepted when i_acc_vld & o_acc_rdy.
  - Output transfers when o_dat_vld & i_dat_rdy.
  - Stage 2 is enabled when it is empty or i_dat_rdy=1.
  - Stage 1 is enabled when it is empty or stage 2 is enabled.
  - o_acc_rdy = stage-1 enable (combinational from i_dat_rdy).
  - Full throughput: one beat per cycle. Latency: 2 cycles from acceptance to o_dat_vld.
  - o_dat, o_relu_en and o_dat_vld hold stable while o_dat_vld=1 and i_dat_rdy=0.
- Stage 1:
  - Per lane: sum = sext33(acc) + sext33(bias[k]), as a 33-bit signed result with no overflow.
  - Register sum, shift, relu_en and valid.
- Stage 2 (per lane):
  - If shift=0, r = sum. Otherwise r = (sum + (1<<(shift-1))) >>> shift, computed in 34 bits so rounding cannot wrap. This is round half up.
  - Saturate r to [-32768, 32767].
  - The lane's sat flag = clamped.
  - Register o_dat, o_relu_en and o_dat_vld.
- Saturation counter:
  - Increments by 1 on each output transfer whose stage-2 beat had any sat flag set.
  - Sticks at 0xFFFF.
  - i_sat_clr has priority over increment and clears the counter to 0.
- Empty pipeline: o_acc_rdy=1 regardless of i_dat_rdy.
- Reset mid-operation: in-flight beats are discarded and no output beat is produced. The bias file is cleared, so the host reloads it.
- i_shift and i_relu_en may change every cycle. Each beat keeps the values sampled at its acceptance.

Decomposition:
- Shared package npu_pkg:
  - LANES, ACC_W, OUT_W, SHIFT_W.
  - Saturation limits OUT_MAX=16'h7FFF and OUT_MIN=16'h8000.
  - Lane slicing helper.
- One sub-module, requant_lane: the combinational per-lane round/shift/saturate, returning a 16-bit value and a sat flag.
- Instantiate requant_lane 32 times in a generate loop.
- Bias file, pipeline registers, handshake and counter stay in bias_requant.

Test Plan:
1. Write bias[0]=16'h0010, bias[31]=16'hFFF0. Send acc lane0=32'h00000100, lane31=32'h00000005, shift=0, i_dat_rdy=1. Expect o_dat lane0=16'h0110 and lane31=16'hFFF5, 2 cycles after acceptance, with o_sat_cnt unchanged.
2. Bias=0, shift=4. Send lane0=24 (→2), lane1=-24 (→-1), lane2=23 (→1). Confirms round half up.
3. Bias=0, shift=0. Send lane0=32'h00010000 (→16'h7FFF) and lane1=32'hFFFF0000 (→16'h8000). Expect o_sat_cnt=1. Then pulse i_sat_clr and expect 0.
4. Stream 8 back-to-back beats, with i_dat_rdy low in cycles 3-5. Expect no loss or duplication, output order preserved, o_dat stable while stalled, and o_acc_rdy=0 only when both stages are full and stalled.
5. Pulse i_bias_wr for lane 0 in the same cycle a beat is accepted. Expect that beat to use the old bias and the next beat to use the new bias.
6. Assert i_rst with 2 beats in flight. Expect o_dat_vld=0 immediately (async), no output after release, and all biases reading as 0 on the next beat.
